// File: rtl/tinyalu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tinyalu_pkg                                               |
// | Brief    : Op codes, FSM states and legality helper for tinyalu.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        sub_op = 3'b101,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    // 3'b110 has no enum member; 3'b111 is reserved for the BFM's reset request.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b110) && (op != rst_op);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tinyalu_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tinyalu_param_if                                          |
// | Brief    : start/done request bus between tinyalu requester and ALU. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface tinyalu_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               err;
    logic               busy;

    modport master (
        output A, B, op, start,
        input  done, result, err, busy
    );

    modport slave (
        input  A, B, op, start,
        output done, result, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/tinyalu_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tinyalu_mul_pipe                                          |
// | Brief    : MUL_LATENCY-stage unsigned multiplier with valid chain.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tinyalu_mul_pipe #(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] product
);

    logic [MUL_LATENCY-1:0] r_vld;
    logic [2*WIDTH-1:0]     r_prod [MUL_LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    // Data stages carry no reset; only the valid chain gives them meaning.
    always_ff @(posedge clk) begin
        r_prod[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        for (int k = 1; k < MUL_LATENCY; k++) begin
            r_prod[k] <= r_prod[k-1];
        end
    end

    assign out_valid = r_vld[MUL_LATENCY-1];
    assign product   = r_prod[MUL_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/tinyalu_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tinyalu_param                                             |
// | Brief    : Parametrised tinyalu: FSM, single-cycle unit, mul pipe.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tinyalu_param
    import tinyalu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    tinyalu_param_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(MUL_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_done;
    logic               r_err;
    logic               r_busy;
    logic [2*WIDTH-1:0] r_result;

    logic               w_mul_start;
    logic               w_mul_valid;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [2*WIDTH-1:0] w_exec_res;

    // The pipe samples the bus directly on the capture edge so the product
    // lands exactly MUL_LATENCY edges later.
    assign w_mul_start = (r_state == IDLE) && bus.start && (bus.op == mul_op);

    tinyalu_mul_pipe #(
        .WIDTH       (WIDTH),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (w_mul_start),
        .a         (bus.A),
        .b         (bus.B),
        .out_valid (w_mul_valid),
        .product   (w_mul_prod)
    );

    always_comb begin
        w_exec_res = '0;
        case (r_op)
            add_op:  w_exec_res = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
            and_op:  w_exec_res = {{WIDTH{1'b0}}, r_a & r_b};
            xor_op:  w_exec_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            sub_op:  w_exec_res = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
            default: w_exec_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= no_op;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // no_op is accepted silently: no busy, no done.
                    if (bus.start && (bus.op != no_op)) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_op    <= bus.op;
                        r_busy  <= 1'b1;
                        r_cnt   <= c_CNT_ONE;
                        r_state <= (bus.op == mul_op) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (is_legal_op(r_op)) begin
                        r_result <= w_exec_res;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                MUL: begin
                    if ((r_cnt == c_MUL_LAST) && w_mul_valid) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_result <= w_mul_prod;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
    assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_tinyalu_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tinyalu_param                                          |
// | Brief    : Self-checking bench for tinyalu_param (8/3 and 16/5).     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_tinyalu_param;

    localparam int W0 = 8;
    localparam int L0 = 3;
    localparam int W1 = 16;
    localparam int L1 = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tinyalu_param_if #(.WIDTH(W0)) b0();
    tinyalu_param_if #(.WIDTH(W1)) b1();

    tinyalu_param #(.WIDTH(W0), .MUL_LATENCY(L0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0)
    );
    tinyalu_param #(.WIDTH(W1), .MUL_LATENCY(L1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU: arithmetic straight from the op definitions, modulo 2^(2w).
    function automatic logic [63:0] ref_alu(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] o, input logic [63:0] prev,
                                            output logic e);
        logic [63:0] m;
        m = (64'd1 << (2 * w)) - 64'd1;
        e = 1'b0;
        case (o)
            3'd1:    return (a + b) & m;
            3'd2:    return a & b;
            3'd3:    return a ^ b;
            3'd4:    return (a * b) & m;
            3'd5:    return (a - b) & m;
            default: begin e = 1'b1; return prev; end
        endcase
    endfunction

    // One BFM-style transaction on the 8-bit instance.
    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        output logic [15:0] res, output logic e, output int lat);
        @(negedge clk);
        b0.A = a; b0.B = b; b0.op = o; b0.start = 1'b1;
        @(posedge clk); #1;
        b0.A = 8'($urandom); b0.B = 8'($urandom); b0.op = 3'($urandom_range(0, 7));
        chk("busy_after_capture", b0.busy, 1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (b0.done) begin
                lat = n;
                break;
            end
            chk("busy_while_pending", b0.busy, 1);
        end
        res = b0.result;
        e   = b0.err;
        if (lat > 0) chk("busy_clear_at_done", b0.busy, 0);
        else         chk("done_timeout", 0, 1);
        @(negedge clk);
        b0.start = 1'b0;
        @(posedge clk); #1;
        chk("done_single_pulse", b0.done, 0);
        chk("err_single_pulse", b0.err, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic        e;
        int          lat;
        logic        seen;
        logic        busy_seen;
        logic [63:0] prev;
        logic [63:0] exp;
        logic        exp_e;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [2:0]  ro;
        int          d1;
        int          d2;
        logic [31:0] r1;
        logic [31:0] r2;

        vecs[0] = '{8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0, 1};
        vecs[1] = '{8'hFF, 8'hFF, 3'd4, 16'hFE01, 1'b0, 3};
        vecs[2] = '{8'hF0, 8'h3C, 3'd2, 16'h0030, 1'b0, 1};
        vecs[3] = '{8'hF0, 8'h3C, 3'd3, 16'h00CC, 1'b0, 1};
        vecs[4] = '{8'h12, 8'h34, 3'd7, 16'h00CC, 1'b1, 1};
        vecs[5] = '{8'h80, 8'h80, 3'd1, 16'h0100, 1'b0, 1};
        vecs[6] = '{8'h00, 8'hFF, 3'd4, 16'h0000, 1'b0, 3};
        vecs[7] = '{8'h00, 8'h01, 3'd5, 16'hFFFF, 1'b0, 1};
        vecs[8] = '{8'h10, 8'h10, 3'd4, 16'h0100, 1'b0, 3};

        reset_n = 1'b0;
        b0.A = '0; b0.B = '0; b0.op = 3'd0; b0.start = 1'b0;
        b1.A = '0; b1.B = '0; b1.op = 3'd0; b1.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", b0.done, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_err", b0.err, 0);
        chk("rst_result", b0.result, 0);
        chk("rst_w16_result", b1.result, 0);
        chk("rst_w16_busy", b1.busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run0(vecs[i].a, vecs[i].b, vecs[i].op, res, e, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_err", i), e, vecs[i].err);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // sub wrap, then no_op held for 8 cycles must stay invisible
        run0(8'h01, 8'h02, 3'd5, res, e, lat);
        chk("sub_wrap_result", res, 16'hFFFF);
        @(negedge clk);
        b0.op = 3'd0; b0.A = 8'h55; b0.B = 8'h66; b0.start = 1'b1;
        seen = 1'b0; busy_seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (b0.done) seen = 1'b1;
            if (b0.busy) busy_seen = 1'b1;
        end
        @(negedge clk);
        b0.start = 1'b0;
        chk("noop_no_done", seen, 0);
        chk("noop_no_busy", busy_seen, 0);
        chk("noop_result_held", b0.result, 16'hFFFF);

        // illegal op keeps the previous result
        run0(8'h10, 8'h20, 3'd1, res, e, lat);
        chk("add_before_illegal", res, 16'h0030);
        run0(8'hAA, 8'h55, 3'b110, res, e, lat);
        chk("illegal_err", e, 1);
        chk("illegal_result_held", res, 16'h0030);
        chk("illegal_latency", lat, 1);

        // reset one cycle into a multiply abandons it
        @(negedge clk);
        b0.A = 8'h07; b0.B = 8'h09; b0.op = 3'd4; b0.start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_done", b0.done, 0);
        chk("midrst_busy", b0.busy, 0);
        chk("midrst_result", b0.result, 0);
        b0.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (b0.done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        run0(8'h02, 8'h03, 3'd1, res, e, lat);
        chk("post_reset_add", res, 16'h0005);
        chk("post_reset_err", e, 0);

        // randomized ops against the reference model
        prev = 64'h5;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 3'($urandom_range(1, 7));
            exp = ref_alu(W0, {56'd0, ra}, {56'd0, rb}, ro, prev, exp_e);
            run0(ra, rb, ro, res, e, lat);
            chk($sformatf("rand%0d_op%0d_result", i, ro), res, exp);
            chk($sformatf("rand%0d_err", i), e, exp_e);
            chk($sformatf("rand%0d_latency", i), lat, (ro == 3'd4) ? L0 : 1);
            prev = exp;
        end

        // 16-bit instance, latency 5 multiply
        @(negedge clk);
        b1.A = 16'hFFFF; b1.B = 16'hFFFF; b1.op = 3'd4; b1.start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (b1.done) begin
                lat = n;
                break;
            end
            chk("w16_busy_while_pending", b1.busy, 1);
        end
        chk("w16_mul_result", b1.result, 32'hFFFE0001);
        chk("w16_mul_latency", lat, L1);
        chk("w16_mul_err", b1.err, 0);
        @(negedge clk);
        b1.start = 1'b0;

        // back-to-back adds with start held through the first done
        @(negedge clk);
        b1.A = 16'h0001; b1.B = 16'h0002; b1.op = 3'd1; b1.start = 1'b1;
        @(posedge clk); #1;
        b1.A = 16'h0100; b1.B = 16'h0200;
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (b1.done) begin
                if (d1 < 0) begin
                    d1 = n; r1 = b1.result;
                end else begin
                    d2 = n; r2 = b1.result;
                    break;
                end
            end
        end
        @(negedge clk);
        b1.start = 1'b0;
        chk("b2b_first_latency", d1, 1);
        chk("b2b_first_result", r1, 32'h0000_0003);
        chk("b2b_gap", d2 - d1, 2);
        chk("b2b_second_result", r2, 32'h0000_0300);
        @(posedge clk); #1;
        chk("b2b_no_third_done", b1.done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
